// File: rtl/asconp_ctrl.sv
// Round sequencer for a single-round Ascon permutation datapath: loads five lanes,
// iterates the external round function nr times, then holds the result for the consumer.
module asconp_ctrl #(
    parameter int WIDTH      = 48,
    parameter int MAX_ROUNDS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_rounds,
    input  logic [WIDTH-1:0] in_s0,
    input  logic [WIDTH-1:0] in_s1,
    input  logic [WIDTH-1:0] in_s2,
    input  logic [WIDTH-1:0] in_s3,
    input  logic [WIDTH-1:0] in_s4,
    output logic [WIDTH-1:0] rnd_s0,
    output logic [WIDTH-1:0] rnd_s1,
    output logic [WIDTH-1:0] rnd_s2,
    output logic [WIDTH-1:0] rnd_s3,
    output logic [WIDTH-1:0] rnd_s4,
    output logic [3:0]       rnd_idx,
    input  logic [WIDTH-1:0] rnd_res_s0,
    input  logic [WIDTH-1:0] rnd_res_s1,
    input  logic [WIDTH-1:0] rnd_res_s2,
    input  logic [WIDTH-1:0] rnd_res_s3,
    input  logic [WIDTH-1:0] rnd_res_s4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s0,
    output logic [WIDTH-1:0] out_s1,
    output logic [WIDTH-1:0] out_s2,
    output logic [WIDTH-1:0] out_s3,
    output logic [WIDTH-1:0] out_s4,
    output logic             busy,
    output logic [3:0]       round_ctr
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [3:0] MAX_NR = 4'(MAX_ROUNDS);

    state_e                  state_q, state_d;
    logic [4:0][WIDTH-1:0]   s_q, s_d;
    logic [4:0][WIDTH-1:0]   in_lanes, res_lanes;
    logic [3:0]              nr_q, nr_d, ctr_q, ctr_d, nr_clamp;
    logic                    out_valid_q, busy_q;

    assign in_lanes  = {in_s4, in_s3, in_s2, in_s1, in_s0};
    assign res_lanes = {rnd_res_s4, rnd_res_s3, rnd_res_s2, rnd_res_s1, rnd_res_s0};
    assign nr_clamp  = (in_rounds > MAX_NR) ? MAX_NR : in_rounds;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        nr_d    = nr_q;
        ctr_d   = ctr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = in_lanes;
                    nr_d    = nr_clamp;
                    ctr_d   = '0;
                    state_d = (nr_clamp != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                s_d   = res_lanes;
                ctr_d = ctr_q + 4'd1;
                if (ctr_q == nr_q - 4'd1) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            nr_q        <= '0;
            ctr_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            nr_q        <= nr_d;
            ctr_q       <= ctr_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == RUN) || (state_d == DONE);
        end
    end

    // Index counts up to 15 on the last round regardless of nr.
    assign rnd_idx   = ctr_q - nr_q;
    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign round_ctr = ctr_q;

    assign {rnd_s4, rnd_s3, rnd_s2, rnd_s1, rnd_s0} = s_q;
    assign {out_s4, out_s3, out_s2, out_s1, out_s0} = s_q;

endmodule

// File: doc/asconp_ctrl.md
# asconp_ctrl

Sequencing controller for the single-round Ascon permutation datapath. It owns the five WIDTH-bit state lanes and accepts a state plus a round count through a valid/ready handshake. It iterates the external combinational round function once per cycle, driving the round-constant index, then presents the permuted state through a second valid/ready handshake. It sits between the mode-level engine (init/absorb/squeeze sequencing) and the round logic, so one round datapath serves both p^a (12 rounds) and p^b (6/8 rounds).

## Interface
- WIDTH, 48, lane width in bits
- MAX_ROUNDS, 12, maximum round count; larger requests saturate to this
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  controller can accept; high only in IDLE and while rst low
- in_rounds  input  4  requested rounds nr; 0 = pass-through, >MAX_ROUNDS saturates
- in_s0..in_s4  input  WIDTH  initial lanes x0..x4
- rnd_s0..rnd_s4  output  WIDTH  current lanes to the round function (equal to the state registers)
- rnd_idx  output  4  round-constant LUT index
- rnd_res_s0..rnd_res_s4  input  WIDTH  round function result, combinational from rnd_s*/rnd_idx
- out_valid  output  1  permuted state available
- out_ready  input  1  consumer accepts
- out_s0..out_s4  output  WIDTH  result lanes (equal to the state registers)
- busy  output  1  high in RUN or DONE
- round_ctr  output  4  rounds completed in the current request

## Operation
- Registers: lanes S0..S4, nr_q[3:0], ctr[3:0], FSM {IDLE, RUN, DONE}.
- IDLE: in_ready=1.
  - On in_valid, load S* <= in_s* and nr_q <= min(in_rounds, MAX_ROUNDS).
  - Clear ctr.
  - Go to RUN if the clamped nr is nonzero, else go to DONE.
- RUN:
  - Each cycle: S* <= rnd_res_s*, ctr <= ctr+1.
  - When ctr == nr_q-1, go to DONE on the same edge.
  - in_valid is ignored.
- DONE:
  - out_valid=1. S* is held stable while out_ready is low.
  - On out_ready, go to IDLE.
  - A new request is accepted no earlier than the cycle after the output handshake.
- rnd_idx = (16 - nr_q + ctr) mod 16, 4-bit wrap. For nr=12 this gives 4..15; for nr=6, 10..15; for nr=8, 8..15. Last round always uses index 15.
- rnd_idx is driven in all states; only RUN values are meaningful.
- out_valid and busy are registered, decoded from FSM state. in_ready = (state==IDLE) & ~rst.

## Timing
- Reset (rst high at an edge): state=IDLE, S*=0, nr_q=0, ctr=0.
  - Outputs after reset: out_valid=0, busy=0, round_ctr=0, rnd_idx=0, out_s*=0.
  - in_ready=0 while rst is high.
- Reset mid-RUN or mid-DONE aborts immediately: the next cycle shows the reset values, and the pending result is discarded.
- Accept at edge E0 (in_valid & in_ready):
  - RUN occupies cycles 1..nr after E0.
  - out_valid rises in cycle nr+1 after E0.
  - Latency nr+1 cycles; nr=0 gives 1 cycle, with out_s* equal to in_s*.
- Throughput: one request per nr+2 cycles with out_ready held high (accept, nr rounds, DONE).
- rnd_s* changes only at RUN edges and at the load edge. rnd_res_s* is sampled only at RUN edges.
- round_ctr equals nr_q while in DONE.
- in_rounds and in_s* are sampled only at the accept edge; later changes have no effect.

## Test plan
- **nr=12:** in_s = {1000808c0001, 94a4b1f09f72, 821ab7ef5039, f6cd3f44a4c2, 03181031374d}, bench round model attached.
  - rnd_idx sequence 4,5,…,15.
  - out_valid exactly 13 cycles after accept.
  - out_s* equals 12 model iterations.
  - busy high for cycles 1..13.
- **nr=6 and nr=8, back-to-back with out_ready=1:**
  - rnd_idx 10..15, then 8..15.
  - Outputs at +7 and +9 cycles.
  - Second accept in the cycle after the first output handshake.
- **nr=0 and nr=15:**
  - nr=0: out_valid at +1 with out_s*=in_s* and no RUN cycles.
  - nr=15: saturates to 12; idx 4..15, output at +13, round_ctr=12 in DONE.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE while in_valid=1.
  - out_s* stays constant; in_ready=0 throughout.
  - After out_ready pulses, in_ready=1 the next cycle and the queued request is accepted.
- **Reset mid-run:** assert rst for one cycle when round_ctr=5 (nr=12).
  - Next cycle: out_valid=0, busy=0, S*=0, rnd_idx=0.
  - in_ready=0 during rst and 1 after release.
  - A fresh nr=12 request then completes normally in 13 cycles.
